// File: rtl/instr_mem_loadable_if.sv
// Fetch and load-stream bundle for the loadable instruction memory.
// The memory side uses the slave modport; the PC/boot loader side uses the master modport.
interface instr_mem_loadable_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 11
);
  logic [ADDR_W-1:0] A;
  logic              fetch_en;
  logic [DATA_W-1:0] RD;
  logic              RD_valid;
  logic              addr_fault;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              busy;
  logic [CNT_W-1:0]  ld_count;
  logic              ld_err;

  modport master (
    output A, fetch_en, ld_start, ld_valid, ld_data, ld_last,
    input  RD, RD_valid, addr_fault, ld_ready, busy, ld_count, ld_err
  );

  modport slave (
    input  A, fetch_en, ld_start, ld_valid, ld_data, ld_last,
    output RD, RD_valid, addr_fault, ld_ready, busy, ld_count, ld_err
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: registered fetch port with range check, plus a
// valid/ready streaming port that writes a program word by word at run time.
//
//   state | meaning
//   RUN   | fetches serviced; ld_start opens a load session
//   LOAD  | words on ld_data written at ld_count; fetch port idle, RD forced to 0
module instr_mem_loadable #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_SHIFT = 2,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst,
  instr_mem_loadable_if.slave bus
);
  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              wr_room;
  logic              ld_acc;
  logic [DATA_W-1:0] rd_q;
  logic              rd_valid_q;
  logic              fault_q;
  logic [CNT_W-1:0]  count_q;
  logic              err_q;

  assign idx      = bus.A >> ADDR_SHIFT;
  assign in_range = 32'(idx) < DEPTH_U;
  assign wr_room  = 32'(count_q) < DEPTH_U;

  always_comb begin
    state_d = state_q;
    ld_acc  = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.ld_start) state_d = LOAD;
      end
      LOAD: begin
        ld_acc = bus.ld_valid;
        if (bus.ld_valid && bus.ld_last) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN) begin
        if (bus.ld_start) begin
          count_q <= '0;
          err_q   <= 1'b0;
        end
        // A fetch in the ld_start cycle is still answered in the first LOAD cycle.
        if (bus.fetch_en) begin
          rd_valid_q <= 1'b1;
          fault_q    <= !in_range;
          rd_q       <= in_range ? mem[idx[IDX_W-1:0]] : '0;
        end else begin
          rd_valid_q <= 1'b0;
          fault_q    <= 1'b0;
        end
      end else begin
        rd_q       <= '0;
        rd_valid_q <= 1'b0;
        fault_q    <= 1'b0;
        if (ld_acc) begin
          if (wr_room) count_q <= count_q + CNT_W'(1);
          else         err_q   <= 1'b1;
        end
      end
    end
  end

  // Array is deliberately outside the reset domain so a reset keeps the program.
  always_ff @(posedge clk) begin
    if (ld_acc && wr_room) mem[count_q[IDX_W-1:0]] <= bus.ld_data;
  end

  assign bus.RD         = rd_q;
  assign bus.RD_valid   = rd_valid_q;
  assign bus.addr_fault = fault_q;
  assign bus.busy       = (state_q == LOAD);
  assign bus.ld_ready   = (state_q == LOAD);
  assign bus.ld_count   = count_q;
  assign bus.ld_err     = err_q;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Randomised bench for instr_mem_loadable (DEPTH = 8) against an array-based model
// of program contents and fetch results.
module tb_instr_mem_loadable;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int DEPTH      = 8;
  localparam int ADDR_SHIFT = 2;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_mem_loadable_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

  instr_mem_loadable #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .ADDR_SHIFT(ADDR_SHIFT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] model_mem   [DEPTH];
  bit          model_known [DEPTH];
  int          model_cnt;
  bit          model_err;
  logic [15:0] exp_rd;
  bit          exp_known;
  bit          exp_valid;
  bit          exp_fault;

  function automatic void model_fetch(input logic [15:0] a, input bit en);
    int idx;
    idx = int'(a >> ADDR_SHIFT);
    if (!en) begin
      exp_valid = 1'b0;
      exp_fault = 1'b0;
    end else if (idx < DEPTH) begin
      exp_valid = 1'b1;
      exp_fault = 1'b0;
      exp_rd    = model_mem[idx];
      exp_known = model_known[idx];
    end else begin
      exp_valid = 1'b1;
      exp_fault = 1'b1;
      exp_rd    = 16'h0000;
      exp_known = 1'b1;
    end
  endfunction

  function automatic void model_load(input logic [15:0] d);
    if (model_cnt < DEPTH) begin
      model_mem[model_cnt]   = d;
      model_known[model_cnt] = 1'b1;
      model_cnt++;
    end else begin
      model_err = 1'b1;
    end
  endfunction

  task automatic fetch_cycle(input logic [15:0] a, input bit en);
    bus.A        = a;
    bus.fetch_en = en;
    @(posedge clk); #1;
    model_fetch(a, en);
  endtask

  // Idle gaps carry ignored ld_last/ld_start noise before the real word.
  task automatic drive_word(input logic [15:0] d, input bit last);
    int gap;
    gap = int'($urandom_range(0, 2));
    repeat (gap) begin
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'($urandom_range(0, 1));
      bus.ld_start = 1'($urandom_range(0, 1));
      bus.ld_data  = 16'($urandom);
      @(posedge clk); #1;
    end
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic start_session();
    bus.ld_start = 1'b1;
    @(posedge clk); #1;
    bus.ld_start = 1'b0;
    model_cnt = 0;
    model_err = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.RD, bus.RD_valid, bus.addr_fault, bus.ld_ready, bus.busy, bus.ld_count, bus.ld_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: outputs %h/%b/%b/%b/%b/%0d/%b expected all zero",
               bus.RD, bus.RD_valid, bus.addr_fault, bus.ld_ready, bus.busy, bus.ld_count, bus.ld_err);
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_tests++;
      if ({bus.RD, bus.RD_valid, bus.addr_fault, bus.ld_ready, bus.busy, bus.ld_count, bus.ld_err} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: outputs %h/%b/%b/%b/%b/%0d/%b expected all zero",
                 bus.RD, bus.RD_valid, bus.addr_fault, bus.ld_ready, bus.busy, bus.ld_count, bus.ld_err);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.RD_valid !== 1'b0 || bus.RD !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b RD_valid=%b RD=%h expected 0/0/0000", bus.busy, bus.RD_valid, bus.RD);
    end
    exp_rd = 16'h0; exp_known = 1'b1;
  endtask

  task automatic test_load_readback();
    logic [15:0] prog [4];
    prog[0] = 16'h0904; prog[1] = 16'h0B30; prog[2] = 16'h12D0; prog[3] = 16'h0003;
    start_session();
    n_tests++;
    if (bus.ld_ready !== 1'b1 || bus.busy !== 1'b1 || bus.ld_count !== '0) begin
      n_fail++;
      $display("FAIL load_enter: ld_ready=%b busy=%b ld_count=%0d expected 1/1/0", bus.ld_ready, bus.busy, bus.ld_count);
    end
    for (int i = 0; i < 4; i++) begin
      drive_word(prog[i], i == 3);
      model_load(prog[i]);
      n_tests++;
      if (bus.ld_count !== CNT_W'(model_cnt) || bus.ld_ready !== (i != 3)) begin
        n_fail++;
        $display("FAIL load_count[%0d]: ld_count=%0d ld_ready=%b expected %0d/%b", i, bus.ld_count, bus.ld_ready, model_cnt, i != 3);
      end
    end
    n_tests++;
    if (bus.ld_err !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done: ld_err=%b busy=%b expected 0/0", bus.ld_err, bus.busy);
    end
    exp_rd = 16'h0;
    for (int i = 0; i < 4; i++) begin
      fetch_cycle(16'(i * 4), 1'b1);
      n_tests++;
      if (bus.RD !== prog[i] || bus.RD_valid !== 1'b1 || bus.addr_fault !== 1'b0) begin
        n_fail++;
        $display("FAIL readback[%0d]: RD=%h valid=%b fault=%b expected %h/1/0", i, bus.RD, bus.RD_valid, bus.addr_fault, prog[i]);
      end
    end
    bus.fetch_en = 1'b0;
  endtask

  task automatic test_overflow();
    logic [15:0] w;
    start_session();
    for (int i = 0; i < 10; i++) begin
      w = 16'($urandom);
      drive_word(w, i == 9);
      model_load(w);
      n_tests++;
      if (bus.ld_count !== CNT_W'(model_cnt) || bus.ld_err !== model_err) begin
        n_fail++;
        $display("FAIL overflow_count[%0d]: ld_count=%0d ld_err=%b expected %0d/%b", i, bus.ld_count, bus.ld_err, model_cnt, model_err);
      end
    end
    n_tests++;
    if (bus.busy !== 1'b0 || bus.ld_ready !== 1'b0 || bus.ld_count !== CNT_W'(DEPTH) || bus.ld_err !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_end: busy=%b ld_ready=%b ld_count=%0d ld_err=%b expected 0/0/%0d/1",
               bus.busy, bus.ld_ready, bus.ld_count, bus.ld_err, DEPTH);
    end
    exp_rd = 16'h0;
    for (int i = 0; i < DEPTH; i++) begin
      fetch_cycle(16'(i * 4), 1'b1);
      n_tests++;
      if (bus.RD !== exp_rd || bus.RD_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL overflow_read[%0d]: RD=%h valid=%b expected %h/1", i, bus.RD, bus.RD_valid, exp_rd);
      end
    end
    bus.fetch_en = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [15:0] addrs [5];
    addrs[0] = 16'h0020; addrs[1] = 16'h001C; addrs[2] = 16'h0023;
    addrs[3] = 16'hFFFF; addrs[4] = 16'h001F;
    for (int i = 0; i < 5; i++) begin
      fetch_cycle(addrs[i], 1'b1);
      n_tests++;
      if (bus.RD_valid !== 1'b1 || bus.addr_fault !== exp_fault || (exp_known && bus.RD !== exp_rd)) begin
        n_fail++;
        $display("FAIL range[A=%h]: RD=%h valid=%b fault=%b expected %h/1/%b", addrs[i], bus.RD, bus.RD_valid, bus.addr_fault, exp_rd, exp_fault);
      end
    end
    bus.fetch_en = 1'b0;
  endtask

  task automatic test_random_fetch();
    logic [15:0] a;
    bit en;
    for (int i = 0; i < 60; i++) begin
      a  = 16'($urandom_range(0, 16'h002F));
      en = ($urandom_range(0, 3) != 0);
      fetch_cycle(a, en);
      n_tests++;
      if (bus.RD_valid !== exp_valid || bus.addr_fault !== exp_fault || (exp_known && bus.RD !== exp_rd)) begin
        n_fail++;
        $display("FAIL rand_fetch[%0d A=%h en=%b]: RD=%h valid=%b fault=%b expected %h/%b/%b",
                 i, a, en, bus.RD, bus.RD_valid, bus.addr_fault, exp_rd, exp_valid, exp_fault);
      end
    end
    bus.fetch_en = 1'b0;
  endtask

  task automatic test_fetch_blocked();
    logic [15:0] a;
    logic [15:0] d;
    bit v;
    int sent;
    int cyc;
    a = 16'($urandom_range(0, DEPTH - 1) * 4);
    bus.A = a; bus.fetch_en = 1'b1;
    start_session();
    model_fetch(a, 1'b1);
    n_tests++;
    if (bus.RD_valid !== 1'b1 || bus.busy !== 1'b1 || (exp_known && bus.RD !== exp_rd)) begin
      n_fail++;
      $display("FAIL blocked_first: RD=%h valid=%b busy=%b expected %h/1/1", bus.RD, bus.RD_valid, bus.busy, exp_rd);
    end
    sent = 0; cyc = 0;
    while (sent < 3 && cyc < 40) begin
      v = (cyc > 20) || ($urandom_range(0, 1) != 0);
      d = 16'($urandom);
      bus.A = 16'($urandom); bus.ld_valid = v; bus.ld_data = d; bus.ld_last = (sent == 2);
      if (v) begin
        model_load(d);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      n_tests++;
      if (bus.RD_valid !== 1'b0 || bus.addr_fault !== 1'b0 || bus.RD !== 16'h0) begin
        n_fail++;
        $display("FAIL blocked_load[%0d]: RD=%h valid=%b fault=%b expected 0000/0/0", cyc, bus.RD, bus.RD_valid, bus.addr_fault);
      end
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.ld_count !== 3'(3)) begin
      n_fail++;
      $display("FAIL blocked_end: busy=%b ld_count=%0d expected 0/3", bus.busy, bus.ld_count);
    end
    exp_rd = 16'h0;
    a = 16'($urandom_range(0, 2) * 4);
    fetch_cycle(a, 1'b1);
    n_tests++;
    if (bus.RD_valid !== 1'b1 || bus.RD !== exp_rd) begin
      n_fail++;
      $display("FAIL blocked_resume: RD=%h valid=%b expected %h/1", bus.RD, bus.RD_valid, exp_rd);
    end
    bus.fetch_en = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] w;
    start_session();
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom);
      drive_word(w, 1'b0);
      model_load(w);
    end
    bus.ld_valid = 1'b1; bus.ld_data = ~model_mem[3]; bus.ld_last = 1'b0;
    #3 rst = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.ld_count !== '0 || bus.ld_ready !== 1'b0 || bus.ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reset: busy=%b ld_count=%0d ld_ready=%b ld_err=%b expected 0/0/0/0",
               bus.busy, bus.ld_count, bus.ld_ready, bus.ld_err);
    end
    bus.ld_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_rd = 16'h0; exp_known = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_cycle(16'(i * 4), 1'b1);
      n_tests++;
      if (bus.RD_valid !== 1'b1 || (exp_known && bus.RD !== exp_rd)) begin
        n_fail++;
        $display("FAIL midload_read[%0d]: RD=%h valid=%b expected %h/1", i, bus.RD, bus.RD_valid, exp_rd);
      end
    end
    bus.fetch_en = 1'b0;
  endtask

  initial begin
    bus.A = '0; bus.fetch_en = 1'b0; bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 16'h0; model_known[i] = 1'b0;
    end
    model_cnt = 0; model_err = 1'b0;
    exp_rd = 16'h0; exp_known = 1'b1; exp_valid = 1'b0; exp_fault = 1'b0;
    test_reset();
    test_load_readback();
    test_overflow();
    test_out_of_range();
    test_random_fetch();
    test_fetch_blocked();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
